// File: rtl/sysx_slave_endpoint_if.sv
// sysX v1 bus signals between the master controller and one slave endpoint.
// Member names keep the endpoint's view: i* driven by the master, o* by the slave.
interface sysx_slave_endpoint_if;
    logic       iBusClock;
    logic [1:0] iBusSelect;
    logic [7:0] iBusMOSI;
    logic [7:0] oBusMISO;
    logic       oBusMISOEnable;
    logic       oBusInterrupt;

    modport master (
        output iBusClock, iBusSelect, iBusMOSI,
        input  oBusMISO, oBusMISOEnable, oBusInterrupt
    );

    modport slave (
        input  iBusClock, iBusSelect, iBusMOSI,
        output oBusMISO, oBusMISOEnable, oBusInterrupt
    );
endinterface

// File: rtl/sysx_slave_endpoint.sv
// sysX v1 slave endpoint: oversamples the master's byte-lane bus in iClkA and
// moves 32-bit words through RX/TX FIFOs with a valid/ready local interface.
module sysx_slave_endpoint #(
    parameter logic [1:0] SELECT_ID = 2'h0,
    parameter int         RX_DEPTH  = 4,
    parameter int         TX_DEPTH  = 4,
    parameter bit         IRQ_ON_RX = 1'b1
) (
    input  logic                  iClkA,
    input  logic                  iReset,
    sysx_slave_endpoint_if.slave  bus,
    output logic [31:0]           oRxData,
    output logic                  oRxValid,
    input  logic                  iRxReady,
    input  logic [31:0]           iTxData,
    input  logic                  iTxValid,
    output logic                  oTxReady,
    input  logic                  iIrqRequest,
    input  logic                  iClearStatus,
    output logic                  oRxOverflow,
    output logic                  oTxUnderrun,
    output logic                  oFrameError
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_ONE = 1;
    localparam logic [TX_AW:0] TX_ONE = 1;

    typedef enum logic [2:0] {
        PH_LOAD  = 3'd0,
        PH_LOLO  = 3'd1,
        PH_LO    = 3'd2,
        PH_HI    = 3'd3,
        PH_HIHI  = 3'd4,
        PH_STORE = 3'd5
    } phase_t;

    logic       busClk_p0, busClk_p1, busClkPrev;
    logic [1:0] busSel_p0, busSel_p1;
    logic [7:0] busMosi_p0, busMosi_p1;
    logic [1:0] syncFill;
    logic       armed, activePrev;
    logic       selected, active, riseStb, fallStb, selStart, selEnd;
    phase_t     phase, phaseNext;
    logic       midWord, capture, commit, txLoad, abortFrame;

    logic [31:0]    rxMem [RX_DEPTH];
    logic [RX_AW:0] rxWr, rxRd;
    logic           rxFull, rxEmpty, rxPush, rxPop;
    logic [31:0]    rxWord;

    logic [31:0]    txMem [TX_DEPTH];
    logic [TX_AW:0] txWr, txRd;
    logic           txFull, txEmpty, txPush, txPop;
    logic [31:0]    txWord;

    // Stage p0/p1: two-flop synchronisers; syncFill marks when p1 holds live pin samples.
    always_ff @(posedge iClkA) begin
        if (iReset) begin
            busClk_p0  <= 1'b1;
            busClk_p1  <= 1'b1;
            busClkPrev <= 1'b1;
            busSel_p0  <= 2'b11;
            busSel_p1  <= 2'b11;
            busMosi_p0 <= 8'h00;
            busMosi_p1 <= 8'h00;
            syncFill   <= 2'b00;
            armed      <= 1'b0;
            activePrev <= 1'b0;
        end else begin
            busClk_p0  <= bus.iBusClock;
            busClk_p1  <= busClk_p0;
            busClkPrev <= busClk_p1;
            busSel_p0  <= bus.iBusSelect;
            busSel_p1  <= busSel_p0;
            busMosi_p0 <= bus.iBusMOSI;
            busMosi_p1 <= busMosi_p0;
            syncFill   <= {syncFill[0], 1'b1};
            // A frame already running when reset lifted stays ignored until the bus idles.
            if (syncFill[1] && busSel_p1 == 2'b11) armed <= 1'b1;
            activePrev <= active;
        end
    end

    assign selected = (busSel_p1 == SELECT_ID);
    assign active   = armed && selected;
    assign riseStb  = busClk_p1 && !busClkPrev;
    assign fallStb  = !busClk_p1 && busClkPrev;
    assign selStart = active && !activePrev;
    assign selEnd   = !active && activePrev;

    assign midWord    = (phase == PH_LOLO) || (phase == PH_LO) || (phase == PH_HI) || (phase == PH_HIHI);
    assign capture    = active && !selStart && fallStb && midWord;
    assign commit     = active && !selStart && riseStb && (phase == PH_HIHI);
    assign txLoad     = selStart || (active && riseStb && (phase == PH_STORE));
    assign abortFrame = selEnd && midWord;

    always_ff @(posedge iClkA) begin
        if (iReset) phase <= PH_LOAD;
        else        phase <= phaseNext;
    end

    always_comb begin
        phaseNext = phase;
        if (selStart || selEnd) begin
            phaseNext = PH_LOAD;
        end else if (active && riseStb) begin
            phaseNext = (phase == PH_STORE) ? PH_LOAD : phase_t'(phase + 3'd1);
        end
    end

    // Stage p2: byte lanes into the RX word, TX word onto MISO.
    always_ff @(posedge iClkA) begin
        if (iReset) begin
            rxWord       <= 32'h0;
            txWord       <= 32'h0;
            bus.oBusMISO <= 8'hFF;
        end else begin
            if (capture) begin
                case (phase)
                    PH_LOLO: rxWord[7:0]   <= busMosi_p1;
                    PH_LO:   rxWord[15:8]  <= busMosi_p1;
                    PH_HI:   rxWord[23:16] <= busMosi_p1;
                    PH_HIHI: rxWord[31:24] <= busMosi_p1;
                    default: ;
                endcase
            end
            if (txLoad) txWord <= txEmpty ? 32'hFFFF_FFFF : txMem[txRd[TX_AW-1:0]];
            if (!active || selStart) begin
                bus.oBusMISO <= 8'hFF;
            end else if (riseStb) begin
                case (phaseNext)
                    PH_LOLO: bus.oBusMISO <= txWord[7:0];
                    PH_LO:   bus.oBusMISO <= txWord[15:8];
                    PH_HI:   bus.oBusMISO <= txWord[23:16];
                    PH_HIHI: bus.oBusMISO <= txWord[31:24];
                    default: bus.oBusMISO <= 8'hFF;
                endcase
            end
        end
    end

    assign bus.oBusMISOEnable = active;

    // Full is judged before any same-cycle pop, so a simultaneous pop cannot rescue a commit.
    assign rxEmpty = (rxWr == rxRd);
    assign rxFull  = (rxWr[RX_AW] != rxRd[RX_AW]) && (rxWr[RX_AW-1:0] == rxRd[RX_AW-1:0]);
    assign rxPush  = commit && !rxFull;
    assign rxPop   = !rxEmpty && iRxReady;
    assign oRxValid = !rxEmpty;
    assign oRxData  = rxMem[rxRd[RX_AW-1:0]];

    assign txEmpty = (txWr == txRd);
    assign txFull  = (txWr[TX_AW] != txRd[TX_AW]) && (txWr[TX_AW-1:0] == txRd[TX_AW-1:0]);
    assign txPush  = iTxValid && !txFull;
    assign txPop   = txLoad && !txEmpty;
    assign oTxReady = !txFull;

    always_ff @(posedge iClkA) begin
        if (rxPush) rxMem[rxWr[RX_AW-1:0]] <= rxWord;
        if (txPush) txMem[txWr[TX_AW-1:0]] <= iTxData;
    end

    always_ff @(posedge iClkA) begin
        if (iReset) begin
            rxWr              <= '0;
            rxRd              <= '0;
            txWr              <= '0;
            txRd              <= '0;
            oRxOverflow       <= 1'b0;
            oTxUnderrun       <= 1'b0;
            oFrameError       <= 1'b0;
            bus.oBusInterrupt <= 1'b0;
        end else begin
            if (rxPush) rxWr <= rxWr + RX_ONE;
            if (rxPop)  rxRd <= rxRd + RX_ONE;
            if (txPush) txWr <= txWr + TX_ONE;
            if (txPop)  txRd <= txRd + TX_ONE;
            oRxOverflow       <= (commit && rxFull) || (oRxOverflow && !iClearStatus);
            oTxUnderrun       <= (txLoad && txEmpty) || (oTxUnderrun && !iClearStatus);
            oFrameError       <= abortFrame || (oFrameError && !iClearStatus);
            bus.oBusInterrupt <= iIrqRequest || (IRQ_ON_RX && oRxValid);
        end
    end
endmodule

// File: tb/tb_sysx_slave_endpoint.sv
// Randomized bench for sysx_slave_endpoint: a behavioural bus master plus a
// queue-based model of the endpoint's FIFOs and flags, checked by scoreboard monitors.
module tb_sysx_slave_endpoint;
    localparam logic [1:0] SEL = 2'h0;
    localparam int RXD = 4;
    localparam int TXD = 4;

    logic        iClkA = 1'b0;
    logic        iReset;
    logic [31:0] oRxData;
    logic        oRxValid, iRxReady;
    logic [31:0] iTxData;
    logic        iTxValid, oTxReady;
    logic        iIrqRequest, iClearStatus;
    logic        oRxOverflow, oTxUnderrun, oFrameError;

    sysx_slave_endpoint_if bus();

    sysx_slave_endpoint #(
        .SELECT_ID(SEL), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .IRQ_ON_RX(1'b1)
    ) dut (
        .iClkA(iClkA), .iReset(iReset), .bus(bus),
        .oRxData(oRxData), .oRxValid(oRxValid), .iRxReady(iRxReady),
        .iTxData(iTxData), .iTxValid(iTxValid), .oTxReady(oTxReady),
        .iIrqRequest(iIrqRequest), .iClearStatus(iClearStatus),
        .oRxOverflow(oRxOverflow), .oTxUnderrun(oTxUnderrun), .oFrameError(oFrameError)
    );

    always #5 iClkA = ~iClkA;

    int checks = 0;
    int failures = 0;
    logic [31:0] expRx[$];
    logic [31:0] expTx[$];
    logic [31:0] gotTx[$];
    logic [31:0] txModel[$];
    logic [31:0] fixedData[$];
    bit mOverflow = 0, mUnderrun = 0, mFrameErr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClkA);
        #1;
    endtask

    // RX scoreboard: every word the DUT hands over must be the oldest accepted one.
    always @(negedge iClkA) begin
        if (!iReset && oRxValid && iRxReady) begin
            if (expRx.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_unexpected actual=%h required=none", oRxData);
            end else begin
                check("rx_word", oRxData, expRx.pop_front());
            end
        end
    end

    // TX scoreboard: words the master read off MISO against what the model predicted.
    always @(negedge iClkA) begin
        if (gotTx.size() != 0) begin
            if (expTx.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_unexpected actual=%h required=none", gotTx.pop_front());
            end else begin
                check("tx_word", gotTx.pop_front(), expTx.pop_front());
            end
        end
    end

    task automatic busPulse(input int h, input bit driveData, input logic [7:0] b);
        bus.iBusClock = 1'b0;
        repeat (h) tick();
        bus.iBusClock = 1'b1;
        if (driveData) bus.iBusMOSI = b;
        repeat (h) tick();
    endtask

    // Master frame: nWords words; abortPhase 1..4 drops select in that phase of word abortWord.
    task automatic runFrame(input logic [1:0] selCode, input int nWords, input int abortWord,
                            input int abortPhase, input int h);
        bit own;
        bit aborting;
        logic [31:0] data, rd, txExp;
        own = (selCode == SEL);
        bus.iBusSelect = selCode;
        repeat (h) tick();
        for (int w = 0; w < nWords; w++) begin
            data = (fixedData.size() != 0) ? fixedData.pop_front() : $urandom;
            aborting = (abortPhase != 0) && (w == abortWord);
            txExp = 32'hFFFF_FFFF;
            if (own) begin
                if (txModel.size() != 0) txExp = txModel.pop_front();
                else mUnderrun = 1;
            end
            if (!aborting) expTx.push_back(txExp);
            rd = 32'h0;
            for (int p = 1; p <= 5; p++) begin
                busPulse(h, p <= 4, (p <= 4) ? data[8*(p-1) +: 8] : 8'h00);
                if (p <= 4) begin
                    rd[8*(p-1) +: 8] = bus.oBusMISO;
                    check("miso_enable", {31'h0, bus.oBusMISOEnable}, {31'h0, own});
                end
                if (aborting && p == abortPhase) begin
                    bus.iBusSelect = 2'b11;
                    mFrameErr = own ? 1'b1 : mFrameErr;
                    repeat (h) tick();
                    return;
                end
            end
            gotTx.push_back(rd);
            if (own) begin
                if (expRx.size() < RXD) expRx.push_back(data);
                else mOverflow = 1;
            end
            if (w < nWords - 1) busPulse(h, 1'b0, 8'h00);
        end
        bus.iBusSelect = 2'b11;
        repeat (h) tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_miso"}, {24'h0, bus.oBusMISO}, 32'hFF);
        check({tag, "_miso_en"}, {31'h0, bus.oBusMISOEnable}, 32'h0);
        check({tag, "_irq"}, {31'h0, bus.oBusInterrupt}, 32'h0);
        check({tag, "_rx_valid"}, {31'h0, oRxValid}, 32'h0);
        check({tag, "_tx_ready"}, {31'h0, oTxReady}, 32'h1);
        check({tag, "_flags"}, {29'h0, oRxOverflow, oTxUnderrun, oFrameError}, 32'h0);
    endtask

    task automatic checkStatus();
        bit irqReq;
        check("rx_valid", {31'h0, oRxValid}, {31'h0, expRx.size() != 0});
        check("tx_ready", {31'h0, oTxReady}, {31'h0, txModel.size() < TXD});
        check("rx_overflow", {31'h0, oRxOverflow}, {31'h0, mOverflow});
        check("tx_underrun", {31'h0, oTxUnderrun}, {31'h0, mUnderrun});
        check("frame_error", {31'h0, oFrameError}, {31'h0, mFrameErr});
        irqReq = 1'($urandom_range(0, 1));
        iIrqRequest = irqReq;
        repeat (2) tick();
        check("bus_irq", {31'h0, bus.oBusInterrupt}, {31'h0, irqReq || (expRx.size() != 0)});
        iIrqRequest = 1'b0;
    endtask

    task automatic clearStatus();
        iClearStatus = 1'b1;
        tick();
        iClearStatus = 1'b0;
        mOverflow = 0; mUnderrun = 0; mFrameErr = 0;
    endtask

    task automatic drainRx();
        int n = 0;
        iRxReady = 1'b1;
        while (oRxValid && n < 50) begin
            tick();
            n++;
        end
        iRxReady = 1'b0;
        tick();
        check("rx_drained", {31'h0, oRxValid}, 32'h0);
        check("rx_model_empty", expRx.size(), 32'h0);
    endtask

    task automatic pushTx(input logic [31:0] word);
        check("tx_ready_pre", {31'h0, oTxReady}, {31'h0, txModel.size() < TXD});
        iTxData = word;
        iTxValid = 1'b1;
        if (txModel.size() < TXD) txModel.push_back(word);
        tick();
        iTxValid = 1'b0;
    endtask

    task automatic resetMidFrame(input int h);
        bus.iBusSelect = SEL;
        repeat (h) tick();
        busPulse(h, 1'b1, 8'h11);
        busPulse(h, 1'b1, 8'h22);
        iReset = 1'b1;
        repeat (2) tick();
        checkResetOutputs("midreset");
        iReset = 1'b0;
        expRx.delete(); txModel.delete();
        mOverflow = 0; mUnderrun = 0; mFrameErr = 0;
        // The frame still in flight must be ignored: no drive, no capture.
        for (int p = 0; p < 8; p++) begin
            busPulse(h, 1'b1, 8'($urandom));
            check("ignored_miso_en", {31'h0, bus.oBusMISOEnable}, 32'h0);
            check("ignored_miso", {24'h0, bus.oBusMISO}, 32'hFF);
        end
        check("ignored_rx_valid", {31'h0, oRxValid}, 32'h0);
        bus.iBusSelect = 2'b11;
        repeat (h) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] selCode;
        int n, aw, ap, r;
        iReset = 1'b1;
        bus.iBusClock = 1'b1; bus.iBusSelect = 2'b11; bus.iBusMOSI = 8'h00;
        iRxReady = 1'b0; iTxData = 32'h0; iTxValid = 1'b0;
        iIrqRequest = 1'b0; iClearStatus = 1'b0;
        repeat (3) tick();
        iReset = 1'b0;
        tick();
        checkResetOutputs("reset");
        repeat (4) tick();

        fixedData.push_back(32'hDEADBEEF);
        pushTx(32'h12345678);
        runFrame(SEL, 1, 0, 0, 6);
        checkStatus();
        check("rx_head_deadbeef", oRxData, 32'hDEADBEEF);
        drainRx();

        runFrame(SEL, 5, 0, 0, 5);
        checkStatus();
        check("overflow_set", {31'h0, oRxOverflow}, 32'h1);
        clearStatus();
        checkStatus();
        drainRx();

        pushTx(32'hA5A5_0F0F);
        runFrame(SEL, 2, 0, 0, 4);
        checkStatus();
        clearStatus();
        drainRx();

        runFrame(SEL, 1, 0, 2, 6);
        checkStatus();
        fixedData.push_back(32'hCAFEF00D);
        runFrame(SEL, 1, 0, 0, 6);
        checkStatus();
        check("rx_head_cafef00d", oRxData, 32'hCAFEF00D);
        clearStatus();
        drainRx();

        for (int i = 0; i < TXD + 1; i++) pushTx($urandom);
        runFrame(2'h1, 2, 0, 0, 5);
        checkStatus();

        resetMidFrame(5);
        checkStatus();

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) clearStatus();
            if ($urandom_range(0, 1) == 0) drainRx();
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) pushTx($urandom);
            r = $urandom_range(0, 9);
            selCode = (r < 8) ? SEL : ((r == 8) ? 2'h1 : 2'h2);
            n = $urandom_range(1, 6);
            aw = 0; ap = 0;
            if ($urandom_range(0, 3) == 0) begin
                aw = $urandom_range(0, n - 1);
                ap = $urandom_range(1, 4);
            end
            runFrame(selCode, n, aw, ap, $urandom_range(4, 7));
            checkStatus();
        end

        drainRx();
        repeat (4) tick();
        check("tx_scoreboard_empty", expTx.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sysx_slave_endpoint.md
Name: sysx_slave_endpoint

Overview:
- Peripheral-side endpoint for the sysX v1 serial bus, directly downstream of the sysX master controller.
- Oversamples the master's bus clock, chip select and 8-bit MOSI lane in the local iClkA domain, and reassembles each 4-byte word into a 32-bit RX FIFO.
- Serves 32-bit words from a TX FIFO onto the 8-bit MISO lane.
- Gives the local peripheral a valid/ready word interface and drives the shared bus interrupt.

Parameters:
SELECT_ID, 2'h0, chip-select code this endpoint answers to (3 = idle, never valid)
RX_DEPTH, 4, RX FIFO depth in words, power of two, 2..16
TX_DEPTH, 4, TX FIFO depth in words, power of two, 2..16
IRQ_ON_RX, 1, when 1 a non-empty RX FIFO asserts oBusInterrupt

Ports:
iClkA  in  1  local clock; all logic is posedge iClkA
iReset  in  1  reset, synchronous, active-high
iBusClock  in  1  master bus clock; idles high
iBusSelect  in  2  master chip select; 3 = idle
iBusMOSI  in  8  master data lane
oBusMISO  out  8  slave data lane
oBusMISOEnable  out  1  high while this endpoint is selected (drives external tri-state)
oBusInterrupt  out  1  level interrupt to master
oRxData  out  32  RX FIFO head
oRxValid  out  1  RX FIFO not empty
iRxReady  in  1  pop RX head when oRxValid high
iTxData  in  32  word to queue for MISO
iTxValid  in  1  push request
oTxReady  out  1  TX FIFO not full
iIrqRequest  in  1  peripheral interrupt request, ORed into oBusInterrupt
iClearStatus  in  1  clears sticky flags
oRxOverflow  out  1  sticky: RX word dropped because FIFO full
oTxUnderrun  out  1  sticky: word sent with TX FIFO empty
oFrameError  out  1  sticky: select dropped mid-word

Behaviour:
- Synchronisers: iBusClock, iBusSelect and iBusMOSI each pass through 2 flops.
- Edge detect on the synchronised clock gives one-cycle rise/fall strobes.
- Constraint: bus clock half-period must be at least 4 iClkA cycles. Faster clocks are unsupported and not checked.
- "Selected" means synchronised select == SELECT_ID.
- Phase counter 0..5 maps to the master pipeline: 0 Load, 1 LoLo, 2 Lo, 3 Hi, 4 HiHi, 5 Store.
  - Select going active sets phase=0 and loads the TX shifter.
  - Each rise while selected advances the phase; 5 wraps to 0.
- MOSI capture happens on a fall strobe in phases 1..4:
  - phase 1 -> bits[7:0]
  - phase 2 -> bits[15:8]
  - phase 3 -> bits[23:16]
  - phase 4 -> bits[31:24]
- Commit happens on a rise strobe that enters phase 5.
  - Assembled word pushes into the RX FIFO.
  - If the RX FIFO is full, the word is dropped and oRxOverflow is set. A same-cycle pop does not rescue the push.
- TX load happens on entry to phase 0 (select assert, or wrap from 5).
  - Pop the TX head into a 32-bit shifter.
  - If the TX FIFO is empty, load 32'hFFFFFFFF and set oTxUnderrun.
- oBusMISO is registered and updated on the rise strobe entering each phase:
  - phase 1 -> shifter[7:0]
  - phase 2 -> [15:8]
  - phase 3 -> [23:16]
  - phase 4 -> [31:24]
  - otherwise 8'hFF
  - 8'hFF when not selected.
- oBusMISOEnable equals selected.
- Deselect:
  - In phase 5 (or before the first rise): normal end, no flag.
  - In phases 1..4: discard the partial word, no RX push, set oFrameError.
  - The popped TX word is lost in both cases; it is not re-queued.
  - On reselect, the phase restarts at 0.
- FIFOs are synchronous. Pointer width is log2(depth) plus 1 wrap bit.
  - Push when iTxValid&&oTxReady.
  - Pop when oRxValid&&iRxReady.
  - Simultaneous push/pop on the local side keeps the count unchanged.
  - Wrap-around is by pointer rollover.
  - oRxData is the combinational head read.
- oBusInterrupt = iIrqRequest | (IRQ_ON_RX & oRxValid), registered.
- Sticky flags:
  - iClearStatus clears all three.
  - A set and a clear in the same cycle resolve to set.
- Reset (at any time, including mid-frame):
  - FIFOs empty, phase=0, shifters 0, sync flops to idle.
  - Sync flop idle values: clock 1, select 3, MOSI 0.
  - Outputs: oBusMISO=8'hFF, oBusMISOEnable=0, oBusInterrupt=0, oRxValid=0, oTxReady=1, all flags 0.
  - After reset, a frame already in progress is ignored until select goes idle, then active again.

Test Plan:
- Single word receive: SELECT_ID=0, master sends 32'hDEADBEEF (bytes EF,BE,AD,DE), half-period 6 cycles -> oRxValid rises after the phase-5 rise; oRxData=32'hDEADBEEF; no flags.
- Single word transmit: push 32'h12345678 before frame -> oBusMISO shows 78,56,34,12 in phases 1..4; master reads 32'h12345678; oTxReady stays 1.
- Block of 5 words with RX_DEPTH=4, iRxReady=0 -> words 1..4 stored in order, 5th dropped, oRxOverflow=1; iClearStatus clears it.
- TX underrun: two-word block with one TX word queued -> first word correct, second reads 32'hFFFFFFFF, oTxUnderrun=1.
- Abort: select to 3 after phase 2 -> no RX push, oFrameError=1; the next full frame 32'hCAFEF00D is received correctly.
- Foreign select (select=1) with a full frame -> oBusMISOEnable=0, oBusMISO=8'hFF, no RX push; reset asserted mid-frame returns all outputs to reset values.
